// File: rtl/bounce_pattern_gen_if.sv
// Control and pattern bundle for bounce_pattern_gen.
// master drives enable/mode/period; slave returns the pattern outputs.
interface bounce_pattern_gen_if #(
   parameter int WIDTH     = 10,
   parameter int DIV_WIDTH = 24
);
   logic                 enable;
   logic [1:0]           mode;
   logic [DIV_WIDTH-1:0] period;
   logic [WIDTH-1:0]     pattern;
   logic                 step;
   logic                 at_edge;
   logic                 direction;

   modport master (
      output enable, mode, period,
      input  pattern, step, at_edge, direction
   );

   modport slave (
      input  enable, mode, period,
      output pattern, step, at_edge, direction
   );
endinterface

// File: rtl/bounce_pattern_gen.sv
// Bouncing LED/bus pattern generator: MIRROR, SCAN and FILL sweeps
// with a programmable prescaler, pause and mode-change restart.
module bounce_pattern_gen #(
   parameter int WIDTH     = 10,
   parameter int DIV_WIDTH = 24
) (
   input logic                 clock,
   input logic                 reset,
   bounce_pattern_gen_if.slave bus
);
   localparam int HALF = WIDTH / 2;
   localparam int PW   = $clog2(WIDTH);

   typedef enum logic {
      OUT = 1'b0,
      IN  = 1'b1
   } dir_e;

   function automatic logic [PW-1:0] pos_max_of(input logic [1:0] m);
      return (m == 2'b01) ? PW'(WIDTH - 1) : PW'(HALF - 1);
   endfunction

   function automatic logic [WIDTH-1:0] enc(input logic [1:0] m,
                                             input logic [PW-1:0] p);
      logic [WIDTH-1:0] r;
      int lo;
      int hi;
      lo = HALF - 1 - int'(p);
      hi = HALF + int'(p);
      r  = '0;
      for (int i = 0; i < WIDTH; i++) begin
         case (m)
            2'b01:   r[i] = (i == int'(p));
            2'b10:   r[i] = (i >= lo) && (i <= hi);
            default: r[i] = (i == lo) || (i == hi);
         endcase
      end
      return r;
   endfunction

   logic [1:0]           mode_q, mode_d;
   logic [PW-1:0]        pos_q, pos_d;
   dir_e                 dir_q, dir_d;
   logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0]     pattern_q, pattern_d;
   logic                 step_q, step_d;
   logic                 at_edge_q, at_edge_d;
   logic [PW-1:0]        pmax;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mode_q    <= 2'b00;
         pos_q     <= '0;
         dir_q     <= OUT;
         cnt_q     <= '0;
         pattern_q <= enc(2'b00, '0);
         step_q    <= 1'b0;
         at_edge_q <= 1'b0;
      end else begin
         mode_q    <= mode_d;
         pos_q     <= pos_d;
         dir_q     <= dir_d;
         cnt_q     <= cnt_d;
         pattern_q <= pattern_d;
         step_q    <= step_d;
         at_edge_q <= at_edge_d;
      end
   end

   always_comb begin
      mode_d    = mode_q;
      pos_d     = pos_q;
      dir_d     = dir_q;
      cnt_d     = cnt_q;
      pattern_d = pattern_q;
      step_d    = 1'b0;
      pmax      = pos_max_of(mode_q);
      if (bus.mode != mode_q) begin
         mode_d    = bus.mode;
         pos_d     = '0;
         dir_d     = OUT;
         cnt_d     = '0;
         pattern_d = enc(bus.mode, '0);
      end else if (bus.enable) begin
         // >= so a period lowered below the running count fires at once
         if (cnt_q >= bus.period) begin
            cnt_d  = '0;
            step_d = 1'b1;
            unique case (dir_q)
               OUT: begin
                  if (pos_q < pmax) begin
                     pos_d = pos_q + PW'(1);
                  end else begin
                     dir_d = IN;
                     pos_d = pos_q - PW'(1);
                  end
               end
               IN: begin
                  if (pos_q != '0) begin
                     pos_d = pos_q - PW'(1);
                  end else begin
                     dir_d = OUT;
                     pos_d = PW'(1);
                  end
               end
            endcase
            pattern_d = enc(mode_q, pos_d);
         end else begin
            cnt_d = cnt_q + DIV_WIDTH'(1);
         end
      end
      at_edge_d = (pos_d == pos_max_of(mode_d));
   end

   assign bus.pattern   = pattern_q;
   assign bus.step      = step_q;
   assign bus.at_edge   = at_edge_q;
   assign bus.direction = dir_q;
endmodule
